// File: rtl/cdc_handshake_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : cdc_handshake_ctrl
// Description : Moves a multi-bit word from the clockA domain to the clockB
//               domain with a req/ack toggle handshake. Only the single-bit
//               req and ack toggles are synchronized; the word itself sits
//               stable in a clockA hold register while it is sampled by B.
// Revision    : 1.0 - initial release
// ============================================================================
module cdc_handshake_ctrl #(
    parameter int WIDTH      = 32,
    parameter int SYNC_DEPTH = 2
) (
    input  logic             clockA,
    input  logic             resetA,
    input  logic             clockB,
    input  logic             resetB,
    input  logic             a_valid,
    output logic             a_ready,
    input  logic [WIDTH-1:0] a_data,
    output logic             a_done,
    output logic             b_valid,
    input  logic             b_ready,
    output logic [WIDTH-1:0] b_data
);

    // A-side states
    localparam logic [1:0] c_A_SETTLE = 2'd0;
    localparam logic [1:0] c_A_IDLE   = 2'd1;
    localparam logic [1:0] c_A_WAIT   = 2'd2;

    // B-side states
    localparam logic [0:0] c_B_IDLE   = 1'b0;
    localparam logic [0:0] c_B_VALID  = 1'b1;

    // Settle window: SYNC_DEPTH+2 clockA cycles so both toggle chains flush
    localparam int                 c_CNT_W       = $clog2(SYNC_DEPTH + 3);
    localparam logic [c_CNT_W-1:0] c_SETTLE_LAST = c_CNT_W'(SYNC_DEPTH + 1);

    // clockA domain
    logic [1:0]            r_stateA;
    logic [c_CNT_W-1:0]    r_settleCnt;
    logic                  r_reqTgl;
    logic [WIDTH-1:0]      r_holdQ;
    logic                  r_aDone;
    logic [SYNC_DEPTH-1:0] r_ackSyncA;
    logic                  w_ackSyncA;
    logic                  w_aReady;

    // clockB domain
    logic [0:0]            r_stateB;
    logic [SYNC_DEPTH-1:0] r_reqSyncB;
    logic                  w_reqSyncB;
    logic                  r_reqSeen;
    logic                  r_ackTgl;
    logic                  r_bValid;
    logic [WIDTH-1:0]      r_bData;

    // Ready is withheld for the cycle a_done pulses, so an accept can only
    // follow an ack return by at least one full clockA cycle.
    assign w_aReady   = (r_stateA == c_A_IDLE) && !r_aDone;
    assign w_ackSyncA = r_ackSyncA[SYNC_DEPTH-1];
    assign w_reqSyncB = r_reqSyncB[SYNC_DEPTH-1];

    assign a_ready = w_aReady;
    assign a_done  = r_aDone;
    assign b_valid = r_bValid;
    assign b_data  = r_bData;

    // Source FSM: settle after reset, accept one word, wait for its ack.
    always_ff @(posedge clockA or posedge resetA) begin
        if (resetA) begin
            r_stateA    <= c_A_SETTLE;
            r_settleCnt <= '0;
            r_reqTgl    <= 1'b0;
            r_holdQ     <= '0;
            r_aDone     <= 1'b0;
        end else begin
            r_aDone <= 1'b0;
            case (r_stateA)
                c_A_SETTLE: begin
                    if (r_settleCnt == c_SETTLE_LAST) begin
                        r_stateA <= c_A_IDLE;
                    end else begin
                        r_settleCnt <= r_settleCnt + 1'b1;
                    end
                end
                c_A_IDLE: begin
                    if (a_valid && w_aReady) begin
                        r_holdQ  <= a_data;
                        r_reqTgl <= ~r_reqTgl;
                        r_stateA <= c_A_WAIT;
                    end
                end
                c_A_WAIT: begin
                    if (w_ackSyncA == r_reqTgl) begin
                        r_aDone  <= 1'b1;
                        r_stateA <= c_A_IDLE;
                    end
                end
                default: begin
                    r_stateA    <= c_A_SETTLE;
                    r_settleCnt <= '0;
                end
            endcase
        end
    end

    // Ack toggle synchronizer into clockA.
    always_ff @(posedge clockA or posedge resetA) begin
        if (resetA) begin
            r_ackSyncA <= '0;
        end else begin
            r_ackSyncA <= {r_ackSyncA[SYNC_DEPTH-2:0], r_ackTgl};
        end
    end

    // Req toggle synchronizer into clockB.
    always_ff @(posedge clockB or posedge resetB) begin
        if (resetB) begin
            r_reqSyncB <= '0;
        end else begin
            r_reqSyncB <= {r_reqSyncB[SYNC_DEPTH-2:0], r_reqTgl};
        end
    end

    // Destination FSM: capture the held word on a new request, present it
    // until the consumer takes it, then return the ack toggle.
    always_ff @(posedge clockB or posedge resetB) begin
        if (resetB) begin
            r_stateB  <= c_B_IDLE;
            r_reqSeen <= 1'b0;
            r_ackTgl  <= 1'b0;
            r_bValid  <= 1'b0;
            r_bData   <= '0;
        end else begin
            case (r_stateB)
                c_B_IDLE: begin
                    if (w_reqSyncB != r_reqSeen) begin
                        // hold register has been stable for SYNC_DEPTH clockB edges
                        r_bData   <= r_holdQ;
                        r_reqSeen <= w_reqSyncB;
                        r_bValid  <= 1'b1;
                        r_stateB  <= c_B_VALID;
                    end
                end
                c_B_VALID: begin
                    if (r_bValid && b_ready) begin
                        r_bValid <= 1'b0;
                        r_ackTgl <= ~r_ackTgl;
                        r_stateB <= c_B_IDLE;
                    end
                end
                default: begin
                    r_stateB <= c_B_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cdc_handshake_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_cdc_handshake_ctrl
// Description : Directed bench for cdc_handshake_ctrl: vector table of single
//               transfers plus back-to-back, reset and clock-ratio sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cdc_handshake_ctrl;

    localparam int SD  = 2;
    localparam int SD3 = 3;

    typedef struct {
        logic [31:0] aData;
        bit          noise;
        int          stall;
        logic [31:0] expData;
    } vec_t;

    // ---- instance 1 (SYNC_DEPTH=2, 100 MHz / 156.25 MHz) ----
    logic        clockA = 1'b0, clockB = 1'b0;
    logic        resetA = 1'b1, resetB = 1'b1;
    logic        a_valid = 1'b0, b_ready = 1'b0;
    logic [31:0] a_data = '0;
    logic        a_ready, a_done, b_valid;
    logic [31:0] b_data;

    // ---- instance 3 (SYNC_DEPTH=3, variable clock ratio) ----
    real         halfA3 = 5.0, halfB3 = 5.0;
    logic        clockA3 = 1'b0, clockB3 = 1'b0;
    logic        resetA3 = 1'b1, resetB3 = 1'b1;
    logic        a_valid3 = 1'b0, b_ready3 = 1'b0;
    logic [31:0] a_data3 = '0;
    logic        a_ready3, a_done3, b_valid3;
    logic [31:0] b_data3;

    int          nVec = 0, nFail = 0;
    logic [31:0] expQ[$];
    logic [31:0] q3[$];
    int          bHs = 0, aDoneCnt = 0, hs3 = 0, done3 = 0;
    bit          monEn = 1'b0, monEn3 = 1'b0;

    cdc_handshake_ctrl #(.WIDTH(32), .SYNC_DEPTH(SD)) u_dut (
        .clockA(clockA), .resetA(resetA), .clockB(clockB), .resetB(resetB),
        .a_valid(a_valid), .a_ready(a_ready), .a_data(a_data), .a_done(a_done),
        .b_valid(b_valid), .b_ready(b_ready), .b_data(b_data)
    );

    cdc_handshake_ctrl #(.WIDTH(32), .SYNC_DEPTH(SD3)) u_dut3 (
        .clockA(clockA3), .resetA(resetA3), .clockB(clockB3), .resetB(resetB3),
        .a_valid(a_valid3), .a_ready(a_ready3), .a_data(a_data3), .a_done(a_done3),
        .b_valid(b_valid3), .b_ready(b_ready3), .b_data(b_data3)
    );

    always #5.0 clockA = ~clockA;
    always #3.2 clockB = ~clockB;
    always #(halfA3) clockA3 = ~clockA3;
    always #(halfB3) clockB3 = ~clockB3;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nVec++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard for instance 1 handshakes
    always @(negedge clockB) begin
        if (monEn && b_valid && b_ready) begin
            bHs++;
            if (expQ.size() == 0) begin
                nVec++;
                nFail++;
                $display("FAIL b_spurious: got 0x%08h, expected no word at %0t", b_data, $time);
            end else begin
                check("b_data_order", b_data, expQ.pop_front());
            end
        end
    end

    // Scoreboard for instance 3 handshakes
    always @(negedge clockB3) begin
        if (monEn3 && b_valid3 && b_ready3) begin
            hs3++;
            if (q3.size() == 0) begin
                nVec++;
                nFail++;
                $display("FAIL b3_spurious: got 0x%08h, expected no word at %0t", b_data3, $time);
            end else begin
                check("b3_data_order", b_data3, q3.pop_front());
            end
        end
    end

    // No word may be presented while the source side is in reset
    always @(negedge clockB) if (resetA) check("b_valid_in_resetA", b_valid, 0);
    always @(negedge clockB3) if (resetA3) check("b3_valid_in_resetA", b_valid3, 0);

    always @(negedge clockA) if (a_done) aDoneCnt++;
    always @(negedge clockA3) if (a_done3) done3++;

    // Random consumer back-pressure for instance 3
    always @(posedge clockB3) begin
        #0.5;
        b_ready3 = ($urandom_range(0, 3) != 0);
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    // Called aligned just after a clockA edge, right after reset release.
    task automatic settleCheck();
        for (int k = 1; k <= SD + 1; k++) begin
            @(posedge clockA); #1;
            check("settle_a_ready_low", a_ready, 0);
            check("settle_b_valid_low", b_valid, 0);
        end
        @(posedge clockA); #1;
        check("settle_a_ready_high", a_ready, 1);
    endtask

    task automatic sendWord(input logic [31:0] d);
        int n;
        n = 0;
        a_valid = 1'b1;
        a_data  = d;
        while (a_ready !== 1'b1 && n < 80) begin
            @(posedge clockA); #1;
            n++;
        end
        check("accept_ready", a_ready, 1);
        @(posedge clockA); #1;
        expQ.push_back(d);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((expQ.size() != 0 || a_ready !== 1'b1) && n < 300) begin
            @(posedge clockA); #1;
            n++;
        end
        check("drain_queue_empty", expQ.size(), 0);
        check("drain_a_ready", a_ready, 1);
    endtask

    task automatic sweep(input real ha, input real hb);
        int n, hs0, d0;
        logic [31:0] d;
        monEn3   = 1'b0;
        a_valid3 = 1'b0;
        resetA3  = 1'b1;
        resetB3  = 1'b1;
        halfA3   = ha;
        halfB3   = hb;
        repeat (4) @(posedge clockA3);
        repeat (4) @(posedge clockB3);
        q3.delete();
        resetA3 = 1'b0;
        resetB3 = 1'b0;
        hs0 = hs3;
        d0  = done3;
        monEn3 = 1'b1;
        @(posedge clockA3); #0.5;
        for (int w = 0; w < 100; w++) begin
            d = $urandom;
            a_valid3 = 1'b1;
            a_data3  = d;
            n = 0;
            while (a_ready3 !== 1'b1 && n < 400) begin
                @(posedge clockA3); #0.5;
                n++;
            end
            check("sweep_accept_ready", a_ready3, 1);
            @(posedge clockA3); #0.5;
            q3.push_back(d);
        end
        a_valid3 = 1'b0;
        n = 0;
        while ((q3.size() != 0 || a_ready3 !== 1'b1) && n < 2000) begin
            @(posedge clockA3); #0.5;
            n++;
        end
        check("sweep_queue_empty", q3.size(), 0);
        check("sweep_b_handshakes", hs3 - hs0, 100);
        check("sweep_a_done_count", done3 - d0, 100);
    endtask

    initial begin
        vec_t vecs[5];
        int   lat, doneBefore, hsBefore, n;

        // {aData, noise on a_data/a_valid while busy, b_ready stall cycles, expected}
        vecs[0] = '{32'hDEADBEEF, 1'b0, 0,  32'hDEADBEEF};
        vecs[1] = '{32'hFFFFFFFF, 1'b0, 20, 32'hFFFFFFFF};
        vecs[2] = '{32'h12345678, 1'b1, 0,  32'h12345678};
        vecs[3] = '{32'hA5A5A5A5, 1'b1, 3,  32'hA5A5A5A5};
        vecs[4] = '{32'h00000001, 1'b0, 1,  32'h00000001};

        // ---- reset state ----
        repeat (4) @(posedge clockA); #1;
        check("rst_a_ready", a_ready, 0);
        check("rst_a_done",  a_done,  0);
        check("rst_b_valid", b_valid, 0);
        check("rst_b_data",  b_data,  0);
        resetA = 1'b0;
        resetB = 1'b0;
        settleCheck();

        // ---- single-word vector table ----
        b_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            n = 0;
            while (a_ready !== 1'b1 && n < 60) begin
                @(posedge clockA); #1;
                n++;
            end
            check("vec_ready", a_ready, 1);
            b_ready = (vecs[i].stall == 0);
            a_valid = 1'b1;
            a_data  = vecs[i].aData;
            @(posedge clockA); #1;
            if (!vecs[i].noise) a_valid = 1'b0;
            check("vec_ready_low", a_ready, 0);
            doneBefore = aDoneCnt;
            lat = 0;
            while (b_valid !== 1'b1 && lat < 20) begin
                @(posedge clockB); #1;
                lat++;
                if (vecs[i].noise) a_data = $urandom;
            end
            a_valid = 1'b0;
            check("vec_latency_ok", (lat >= SD && lat <= SD + 2), 1);
            check("vec_b_data", b_data, vecs[i].expData);
            for (int s = 0; s < vecs[i].stall; s++) begin
                @(posedge clockB); #1;
                check("stall_b_valid", b_valid, 1);
                check("stall_b_data", b_data, vecs[i].expData);
                check("stall_a_ready", a_ready, 0);
            end
            check("stall_no_done", aDoneCnt - doneBefore, 0);
            b_ready = 1'b1;
            n = 0;
            while (a_ready !== 1'b1 && n < 40) begin
                @(posedge clockA); #1;
                n++;
            end
            check("vec_a_ready_back", a_ready, 1);
            check("vec_one_done", aDoneCnt - doneBefore, 1);
            check("vec_b_valid_dropped", b_valid, 0);
        end

        // ---- back-to-back 0..15 with a_valid held high ----
        monEn      = 1'b1;
        hsBefore   = bHs;
        doneBefore = aDoneCnt;
        for (int w = 0; w < 16; w++) sendWord(w);
        a_valid = 1'b0;
        drain();
        check("b2b_handshakes", bHs - hsBefore, 16);
        check("b2b_a_done_count", aDoneCnt - doneBefore, 16);

        // ---- reset in A_WAIT with a word parked on B ----
        monEn   = 1'b0;
        b_ready = 1'b0;
        a_valid = 1'b1;
        a_data  = 32'h11111111;
        @(posedge clockA); #1;
        a_valid = 1'b0;
        check("mid_a_ready_low", a_ready, 0);
        repeat (SD + 4) @(posedge clockB);
        #1;
        check("mid_b_valid_before_reset", b_valid, 1);
        resetA = 1'b1;
        resetB = 1'b1;
        repeat (3) @(posedge clockA); #1;
        check("mid_rst_a_ready", a_ready, 0);
        check("mid_rst_a_done",  a_done,  0);
        check("mid_rst_b_valid", b_valid, 0);
        check("mid_rst_b_data",  b_data,  0);
        expQ.delete();
        resetA = 1'b0;
        resetB = 1'b0;
        settleCheck();
        b_ready  = 1'b1;
        monEn    = 1'b1;
        hsBefore = bHs;
        sendWord(32'h5A5A5A5A);
        a_valid = 1'b0;
        drain();
        repeat (10) @(posedge clockB);
        #1;
        check("post_reset_one_handshake", bHs - hsBefore, 1);
        check("post_reset_b_valid_idle", b_valid, 0);
        monEn = 1'b0;

        // ---- clock ratio sweep on SYNC_DEPTH=3 instance ----
        sweep(2.0, 8.0);   // clockA:clockB = 4:1
        sweep(8.0, 2.0);   // clockA:clockB = 1:4

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nFail);
        $finish;
    end

endmodule
`default_nettype wire
